mem_init_seq: RTL and testbench

MEM_INIT_SEQ -- requirements
Module: mem_init_seq

---
 rtl/mem_init_seq.sv | 211 +++++++++++++++++++++
 tb/tb_mem_init_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_init_seq.sv
// mem_init_seq -- memory initialisation sequencer.
//
// Each start walks the addresses idx = 0, STRIDE, 2*STRIDE, ... while
// idx < LIMIT. For each address it writes wdata = idx (zero-extended or
// truncated to DATA_W). Every write is held until the memory raises wr_ready.
//
// Optional feature, selected by the macro MEM_INIT_VERIFY_EN:
//   A readback pass follows the write pass. It walks the same addresses and
//   compares rdata with the value that was written. The first failing address
//   is latched in err_addr, and err is sticky until the next start.
//   Without the macro, re, err and err_addr are tied to 0 and rdata is ignored.
//
// Ports:
//   Clk       in   1       rising-edge clock
//   Rst       in   1       asynchronous active-high reset
//   start     in   1       begin an init pass (sampled only when not busy)
//   wr_ready  in   1       memory accepts the current write this cycle
//   rdata     in   DATA_W  read data, valid one cycle after re (verify build)
//   we        out  1       write request
//   re        out  1       read request (verify build)
//   addr      out  ADDR_W  write/read address
//   wdata     out  DATA_W  write data
//   busy      out  1       pass in progress
//   done      out  1       pass complete, held until next start or Rst
//   err       out  1       sticky readback mismatch (verify build)
//   err_addr  out  ADDR_W  first failing address (verify build)
module mem_init_seq #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int STRIDE = 2,
   parameter int LIMIT  = 10
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              start,
   input  logic              wr_ready,
   input  logic [DATA_W-1:0] rdata,
   output logic              we,
   output logic              re,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr
);

   // Step and bound are held one bit wider than an address, so the sum
   // idx + STRIDE can never wrap back to a low address.
   localparam logic [ADDR_W:0]   STEP   = (ADDR_W+1)'(STRIDE);
   localparam logic [ADDR_W:0]   BOUND  = (ADDR_W+1)'(LIMIT);
   localparam logic [ADDR_W:0]   ZERO_B = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

`ifdef MEM_INIT_VERIFY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WRITE  = 3'd1,
      DONE   = 3'd2,
      VERIFY = 3'd3,
      VWAIT  = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      DONE  = 3'd2
   } state_t;
`endif

   // Map an address onto the data bus: zero-extend or truncate to DATA_W.
   function automatic logic [DATA_W-1:0] fit_data(input logic [ADDR_W-1:0] a);
      logic [DATA_W+ADDR_W-1:0] ext;
      ext = {{DATA_W{1'b0}}, a};
      return ext[DATA_W-1:0];
   endfunction

   state_t            state_r;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W:0]   next_s;
   logic              last_s;

   // Next walk position; the pass ends once it reaches the exclusive bound.
   assign next_s = {1'b0, idx_r} + STEP;
   assign last_s = (next_s >= BOUND);

`ifndef MEM_INIT_VERIFY_EN
   logic unused_rdata_s;

   assign unused_rdata_s = ^rdata;
   assign re             = 1'b0;
   assign err            = 1'b0;
   assign err_addr       = ZERO_A;
`endif

   // Sequencer FSM; all outputs are registered alongside the state.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r  <= IDLE;
         idx_r    <= ZERO_A;
         we       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         addr     <= ZERO_A;
         wdata    <= ZERO_D;
`ifdef MEM_INIT_VERIFY_EN
         re       <= 1'b0;
         err      <= 1'b0;
         err_addr <= ZERO_A;
`endif
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  idx_r <= ZERO_A;
                  addr  <= ZERO_A;
                  wdata <= ZERO_D;
`ifdef MEM_INIT_VERIFY_EN
                  err      <= 1'b0;
                  err_addr <= ZERO_A;
`endif
                  if (BOUND == ZERO_B) begin
                     // Empty range: report completion without any write.
                     state_r <= DONE;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     we      <= 1'b0;
                  end else begin
                     state_r <= WRITE;
                     done    <= 1'b0;
                     busy    <= 1'b1;
                     we      <= 1'b1;
                  end
               end else begin
                  state_r <= state_r;
               end
            end

            WRITE: begin
               // we is high throughout WRITE, so wr_ready alone marks acceptance.
               if (wr_ready) begin
                  if (last_s) begin
                     we    <= 1'b0;
                     idx_r <= ZERO_A;
                     addr  <= ZERO_A;
                     wdata <= ZERO_D;
`ifdef MEM_INIT_VERIFY_EN
                     state_r <= VERIFY;
                     re      <= 1'b1;
`else
                     state_r <= DONE;
                     busy    <= 1'b0;
                     done    <= 1'b1;
`endif
                  end else begin
                     idx_r <= next_s[ADDR_W-1:0];
                     addr  <= next_s[ADDR_W-1:0];
                     wdata <= fit_data(next_s[ADDR_W-1:0]);
                  end
               end else begin
                  state_r <= state_r;
               end
            end

`ifdef MEM_INIT_VERIFY_EN
            VERIFY: begin
               // The read strobe lasts one cycle; data arrives in VWAIT.
               re      <= 1'b0;
               state_r <= VWAIT;
            end

            VWAIT: begin
               if ((rdata != fit_data(idx_r)) && !err) begin
                  err      <= 1'b1;
                  err_addr <= idx_r;
               end else begin
                  err <= err;
               end
               if (last_s) begin
                  state_r <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  idx_r   <= ZERO_A;
                  addr    <= ZERO_A;
               end else begin
                  state_r <= VERIFY;
                  idx_r   <= next_s[ADDR_W-1:0];
                  addr    <= next_s[ADDR_W-1:0];
                  re      <= 1'b1;
               end
            end
`endif

            default: begin
               state_r <= IDLE;
               idx_r   <= ZERO_A;
               we      <= 1'b0;
               busy    <= 1'b0;
               done    <= 1'b0;
               addr    <= ZERO_A;
               wdata   <= ZERO_D;
`ifdef MEM_INIT_VERIFY_EN
               re      <= 1'b0;
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_init_seq.sv
// Directed testbench for mem_init_seq.
// Instance "dut" uses the default parameters, "dut_l0" uses LIMIT=0, and
// "dut_s3" uses STRIDE=3 with LIMIT=16.
// A memory model stores accepted writes, corrupts address 4 to 8'hFF, and
// returns read data one cycle after re.
`timescale 1ns/1ps
module tb_mem_init_seq;

   int checks = 0;
   int errors = 0;

   logic Clk = 1'b0;
   logic Rst = 1'b1;

   // default instance
   logic       start = 1'b0;
   logic       wr_ready = 1'b1;
   logic [7:0] rdata = 8'h00;
   logic       we, re, busy, done, err;
   logic [3:0] addr, err_addr;
   logic [7:0] wdata;
   logic [7:0] mem [0:15];

   // LIMIT = 0 instance
   logic       start0 = 1'b0;
   logic       ready0 = 1'b1;
   logic [7:0] rdata0 = 8'h00;
   logic       we0, re0, busy0, done0, err0;
   logic [3:0] addr0, err_addr0;
   logic [7:0] wdata0;

   // STRIDE = 3, LIMIT = 16 instance
   logic       start3 = 1'b0;
   logic       ready3 = 1'b1;
   logic [7:0] rdata3 = 8'h00;
   logic       we3, re3, busy3, done3, err3;
   logic [3:0] addr3, err_addr3;
   logic [7:0] wdata3;

   always #5 Clk = ~Clk;

   mem_init_seq dut (
      .Clk(Clk), .Rst(Rst), .start(start), .wr_ready(wr_ready), .rdata(rdata),
      .we(we), .re(re), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
      .err(err), .err_addr(err_addr)
   );

   mem_init_seq #(.ADDR_W(4), .DATA_W(8), .STRIDE(2), .LIMIT(0)) dut_l0 (
      .Clk(Clk), .Rst(Rst), .start(start0), .wr_ready(ready0), .rdata(rdata0),
      .we(we0), .re(re0), .addr(addr0), .wdata(wdata0), .busy(busy0), .done(done0),
      .err(err0), .err_addr(err_addr0)
   );

   mem_init_seq #(.ADDR_W(4), .DATA_W(8), .STRIDE(3), .LIMIT(16)) dut_s3 (
      .Clk(Clk), .Rst(Rst), .start(start3), .wr_ready(ready3), .rdata(rdata3),
      .we(we3), .re(re3), .addr(addr3), .wdata(wdata3), .busy(busy3), .done(done3),
      .err(err3), .err_addr(err_addr3)
   );

   // Memory model with a stuck location at address 4.
   always @(posedge Clk) begin
      if (we && wr_ready) mem[addr] <= (addr == 4'd4) ? 8'hFF : wdata;
      if (re) rdata <= mem[addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check(tag, 32'(we), 32'd0);
      check(tag, 32'(re), 32'd0);
      check(tag, 32'(busy), 32'd0);
      check(tag, 32'(done), 32'd0);
      check(tag, 32'(err), 32'd0);
      check(tag, 32'(addr), 32'd0);
      check(tag, 32'(wdata), 32'd0);
      check(tag, 32'(err_addr), 32'd0);
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 60 && !done; i++) tick();
      check(tag, 32'(done), 32'd1);
   endtask

   initial begin
      // Reset state, then idle after release.
      tick();
      tick();
      check_idle("reset_state");
      Rst = 1'b0;
      tick();
      tick();
      check_idle("idle_after_reset");

      // Basic pass with wr_ready held high.
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("p1_we", 32'(we), 32'd1);
         check("p1_busy", 32'(busy), 32'd1);
         check("p1_addr", 32'(addr), 32'(2*k));
         check("p1_wdata", 32'(wdata), 32'(2*k));
         tick();
      end
`ifndef MEM_INIT_VERIFY_EN
      check("p1_done_cycle6", 32'(done), 32'd1);
      check("p1_we_off", 32'(we), 32'd0);
      check("p1_busy_off", 32'(busy), 32'd0);
      check("p1_addr_idle", 32'(addr), 32'd0);
`else
      check("v_busy_in_verify", 32'(busy), 32'd1);
      wait_done("v_done");
      check("v_err", 32'(err), 32'd1);
      check("v_err_addr", 32'(err_addr), 32'd4);
`endif
      tick();
      tick();
      check("p1_done_holds", 32'(done), 32'd1);

      // Backpressure on address 4; the new start also clears done and err.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("p2_done_clear", 32'(done), 32'd0);
      check("p2_err_clear", 32'(err), 32'd0);
      check("p2_addr0", 32'(addr), 32'd0);
      tick();
      check("p2_addr2", 32'(addr), 32'd2);
      tick();
      wr_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) wr_ready = 1'b1;
         check("p2_hold_we", 32'(we), 32'd1);
         check("p2_hold_addr", 32'(addr), 32'd4);
         check("p2_hold_wdata", 32'(wdata), 32'd4);
         tick();
      end
      check("p2_addr6", 32'(addr), 32'd6);
      tick();
      check("p2_addr8", 32'(addr), 32'd8);
      tick();
`ifndef MEM_INIT_VERIFY_EN
      check("p2_done", 32'(done), 32'd1);
      check("p2_we_off", 32'(we), 32'd0);
`else
      wait_done("p2_v_done");
`endif

      // A start while busy is ignored.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("p3_addr0", 32'(addr), 32'd0);
      tick();
      check("p3_addr2", 32'(addr), 32'd2);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("p3_addr4", 32'(addr), 32'd4);
      check("p3_busy", 32'(busy), 32'd1);
      tick();
      check("p3_addr6", 32'(addr), 32'd6);
      tick();
      check("p3_addr8", 32'(addr), 32'd8);
      tick();
`ifndef MEM_INIT_VERIFY_EN
      check("p3_done", 32'(done), 32'd1);
`else
      wait_done("p3_v_done");
`endif

      // Rst pulse during the write of address 6.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check("p4_addr6", 32'(addr), 32'd6);
      Rst = 1'b1;
      #1;
      check_idle("p4_async_reset");
      tick();
      check_idle("p4_reset_held");
      Rst = 1'b0;
      tick();
      check_idle("p4_wait_start");
      start = 1'b1;
      tick();
      start = 1'b0;
      check("p4_restart_we", 32'(we), 32'd1);
      check("p4_restart_addr", 32'(addr), 32'd0);
      wait_done("p4_done");

      // LIMIT = 0: done on the next cycle, and no write is ever issued.
      check("l0_idle", 32'(done0), 32'd0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("l0_done", 32'(done0), 32'd1);
      check("l0_we", 32'(we0), 32'd0);
      check("l0_busy", 32'(busy0), 32'd0);
      tick();
      check("l0_done_hold", 32'(done0), 32'd1);
      check("l0_we_hold", 32'(we0), 32'd0);

      // STRIDE = 3, LIMIT = 16: addresses 0,3,...,15 with no wrap.
      start3 = 1'b1;
      tick();
      start3 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         check("s3_we", 32'(we3), 32'd1);
         check("s3_addr", 32'(addr3), 32'(3*k));
         check("s3_wdata", 32'(wdata3), 32'(3*k));
         tick();
      end
`ifndef MEM_INIT_VERIFY_EN
      check("s3_done", 32'(done3), 32'd1);
      check("s3_we_off", 32'(we3), 32'd0);
`else
      for (int i = 0; i < 60 && !done3; i++) tick();
      check("s3_v_done", 32'(done3), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
